// File: rtl/cpu_bus_arb_pkg.sv
// cpu_bus_arb_pkg
//   Shared definitions for the cpu_bus two-master arbiter:
//   - WLEN transfer-size codes (same encoding cpu_bus uses on WLEN)
//   - arbiter FSM state encoding (2 bits)
//   - default watchdog limit for the optional timeout feature
//     (enabled by defining CPU_BUS_ARB_TIMEOUT_EN)
package cpu_bus_arb_pkg;

    typedef enum logic [1:0] {
        WLEN_RD32 = 2'b00,
        WLEN_WR8  = 2'b01,
        WLEN_WR16 = 2'b10,
        WLEN_WR32 = 2'b11
    } wlen_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_LOW  = 2'b10,
        ST_WAIT_HIGH = 2'b11
    } arb_state_e;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/cpu_bus_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational 2-way round-robin picker.
//   Ports:
//     req[1:0]    in   eligible requesters
//     last_grant  in   id of the most recently completed grant
//     valid       out  at least one requester eligible
//     id          out  chosen requester (meaningful when valid=1)
//   A lone requester always wins; on a tie the one not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       id
);

    always_comb begin
        valid = |req;
        id    = (&req) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
//   Shares the single cpu_bus master port between m0 (CPU load/store unit)
//   and m1 (secondary requester). One transaction at a time, round-robin.
//   The winner's command is latched at grant, EN_N is pulsed low for one
//   cycle, then READY is followed low and back high; read data and a
//   one-cycle ack are returned to the winner. All outputs are registered.
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     mN_req/addr/wdata/wlen     requester command (held until mN_ack)
//     mN_ack/rdata/err           completion pulse, read data, timeout flag
//     bus_addr/wdata/wlen/en_n   cpu_bus command outputs
//     bus_ready/rdata            cpu_bus response inputs
//     grant_id                   master currently or last granted
//     busy                       high whenever the FSM is not idle
//   Optional feature: define CPU_BUS_ARB_TIMEOUT_EN to add a watchdog that
//   ends a stuck wait after TIMEOUT_CYCLES with ack+err. Without it the
//   err outputs are tied low and waits are unbounded.
module cpu_bus_arbiter
    import cpu_bus_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [1:0]        m0_wlen,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [1:0]        m1_wlen,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [1:0]        bus_wlen,
    output logic              bus_en_n,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              grant_id,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              en_n_q, en_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        wlen_q, wlen_d;
    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              gid_q, gid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;

    // A request is ignored in its own ack cycle so a held req is not re-served.
    logic [1:0] elig;
    logic       pick_valid;
    logic       pick_id;

    assign elig = {m1_req & ~ack_q[1], m0_req & ~ack_q[0]};

    rr_pick2 u_pick (
        .req        (elig),
        .last_grant (last_q),
        .valid      (pick_valid),
        .id         (pick_id)
    );

`ifdef CPU_BUS_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] err_q, err_d;
    logic       to_hit;

    // Fires on the wait cycle in which the count would reach the limit.
    assign to_hit = (cnt_q + 8'd1) == 8'(TIMEOUT_CYCLES);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT_LOW || state_q == ST_WAIT_HIGH) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign m0_err = err_q[0];
    assign m1_err = err_q[1];
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        en_n_d   = en_n_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wlen_d   = wlen_q;
        ack_d    = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gid_d    = gid_q;
        last_d   = last_q;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
        err_d    = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gid_d   = pick_id;
                    addr_d  = pick_id ? m1_addr  : m0_addr;
                    wdata_d = pick_id ? m1_wdata : m0_wdata;
                    wlen_d  = pick_id ? m1_wlen  : m0_wlen;
                    en_n_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                en_n_d  = 1'b1;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!bus_ready) begin
                    state_d = ST_WAIT_HIGH;
                end
`ifdef CPU_BUS_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    ack_d[gid_q] = 1'b1;
                    err_d[gid_q] = 1'b1;
                    state_d      = ST_IDLE;
                end
`endif
            end
            ST_WAIT_HIGH: begin
                if (bus_ready) begin
                    if (gid_q) rdata1_d = bus_rdata;
                    else       rdata0_d = bus_rdata;
                    ack_d[gid_q] = 1'b1;
                    last_d       = gid_q;
                    state_d      = ST_IDLE;
                end
`ifdef CPU_BUS_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    ack_d[gid_q] = 1'b1;
                    err_d[gid_q] = 1'b1;
                    state_d      = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            en_n_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            wlen_q   <= '0;
            ack_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            gid_q    <= 1'b0;
            last_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_n_q   <= en_n_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wlen_q   <= wlen_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            gid_q    <= gid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end

    assign bus_en_n  = en_n_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_wlen  = wlen_q;
    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign grant_id  = gid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: cpu_bus stub, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_cpu_bus_arbiter;
    import cpu_bus_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [1:0]  m0_wlen = '0, m1_wlen = '0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata;
    logic [1:0]  bus_wlen;
    logic        bus_en_n;
    logic        bus_ready = 1'b1;
    logic [31:0] bus_rdata = '0;
    logic        grant_id, busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wlen(m0_wlen),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wlen(m1_wlen),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wlen(bus_wlen),
        .bus_en_n(bus_en_n), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // cpu_bus stub: after seeing EN_N low, drops READY for 3 cycles
    // (2 for WR16), then raises it again.
    bit stub_en = 1'b1;
    int stub_cnt = 0;
    always @(posedge clk or posedge reset) begin
        if (reset || !stub_en) begin
            stub_cnt  = 0;
            bus_ready = 1'b1;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                #1 bus_ready = 1'b1;
            end
        end else if (!bus_en_n) begin
            stub_cnt = (bus_wlen == WLEN_WR16) ? 2 : 3;
            #1 bus_ready = 1'b0;
        end
    end

    // Transaction-level model: one transaction at a time, lone requester
    // wins, ties go to the master not served last, completion after the
    // fixed latency (4 for WR16, else 5).
    bit          model_en = 1'b1;
    logic        m_en_n = 1'b1, m_busy = 1'b0, m_gid = 1'b0, m_last = 1'b1;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [1:0]  m_wlen = '0, m_ack = '0, m_err = '0;
    logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
    int          m_left = 0;
    logic        e0, e1, w;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_en_n = 1'b1; m_busy = 1'b0; m_gid = 1'b0; m_last = 1'b1;
            m_addr = '0; m_wdata = '0; m_wlen = '0; m_ack = '0; m_err = '0;
            m_rdata[0] = '0; m_rdata[1] = '0; m_left = 0;
        end else begin
            e0 = m0_req && !m_ack[0];
            e1 = m1_req && !m_ack[1];
            m_ack = '0;
            m_err = '0;
            if (m_busy) begin
                m_en_n = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_ack[m_gid] = 1'b1;
                    m_rdata[m_gid] = bus_rdata;
                    m_last = m_gid;
                end
            end else if (e0 || e1) begin
                w = (e0 && e1) ? !m_last : e1;
                m_gid   = w;
                m_addr  = w ? m1_addr  : m0_addr;
                m_wdata = w ? m1_wdata : m0_wdata;
                m_wlen  = w ? m1_wlen  : m0_wlen;
                m_en_n  = 1'b0;
                m_busy  = 1'b1;
                m_left  = (m_wlen == WLEN_WR16) ? 4 : 5;
            end
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            chk("cmp_bus_en_n",  bus_en_n,  m_en_n);
            chk("cmp_busy",      busy,      m_busy);
            chk("cmp_grant_id",  grant_id,  m_gid);
            chk("cmp_bus_addr",  bus_addr,  m_addr);
            chk("cmp_bus_wdata", bus_wdata, m_wdata);
            chk("cmp_bus_wlen",  bus_wlen,  m_wlen);
            chk("cmp_m0_ack",    m0_ack,    m_ack[0]);
            chk("cmp_m1_ack",    m1_ack,    m_ack[1]);
            chk("cmp_m0_err",    m0_err,    m_err[0]);
            chk("cmp_m1_err",    m1_err,    m_err[1]);
            chk("cmp_m0_rdata",  m0_rdata,  m_rdata[0]);
            chk("cmp_m1_rdata",  m1_rdata,  m_rdata[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, follow it to its ack (bounded), then drop req.
    task automatic run_txn(input int m, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] wl, input bit move_addr,
                           output int lat, output int enlow);
        bit granted = 1'b0;
        bit oth     = 1'b0;
        lat   = -1;
        enlow = 0;
        if (m == 0) begin
            m0_addr = a; m0_wdata = wd; m0_wlen = wl; m0_req = 1'b1;
        end else begin
            m1_addr = a; m1_wdata = wd; m1_wlen = wl; m1_req = 1'b1;
        end
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (!bus_en_n) begin
                enlow++;
                if (!granted && move_addr) m0_addr = 32'h20;
                granted = 1'b1;
            end
            if (granted) begin
                chk("bus_addr_hold", bus_addr, a);
                chk("bus_wlen_hold", bus_wlen, wl);
            end
            if ((m == 0) ? m1_ack : m0_ack) oth = 1'b1;
            if ((m == 0) ? m0_ack : m1_ack) begin
                lat = i - 1;
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("ack_seen", lat >= 0, 1);
        chk("other_ack_quiet", oth, 0);
    endtask

    int lat, enlow, ng;
    logic [1:0] gseq [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        #3;
        chk("rst_bus_en_n", bus_en_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // m0 RD32 @0x10
        bus_rdata = 32'h12345678;
        run_txn(0, 32'h10, 32'h0, WLEN_RD32, 1'b0, lat, enlow);
        chk("t1_latency", lat, 5);
        chk("t1_en_low_cycles", enlow, 1);
        chk("t1_m0_rdata", m0_rdata, 32'h12345678);
        chk("t1_m1_rdata", m1_rdata, 32'h0);
        tick(); tick();

        // m1 WR16 @0x80000
        bus_rdata = 32'hDEADBEEF;
        run_txn(1, 32'h80000, 32'h3FF, WLEN_WR16, 1'b0, lat, enlow);
        chk("t2_latency", lat, 4);
        chk("t2_bus_wdata", bus_wdata, 32'h3FF);
        chk("t2_busy_after_ack", busy, 0);
        tick();
        chk("t2_busy_next", busy, 0);
        tick();

        // Both request continuously: expect m0,m1,m0,m1
        m0_addr = 32'h100; m0_wlen = WLEN_RD32; m0_wdata = 32'h1;
        m1_addr = 32'h200; m1_wlen = WLEN_WR32; m1_wdata = 32'h2;
        m0_req = 1'b1; m1_req = 1'b1;
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            tick();
            if (!bus_en_n) begin
                gseq[ng] = {1'b0, grant_id};
                ng++;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("t3_grant_count", ng, 4);
        chk("t3_order", {gseq[0], gseq[1], gseq[2], gseq[3]}, 8'b00_01_00_01);
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("t3_drained", busy, 0);
        tick();

        // Payload change after grant is ignored
        run_txn(0, 32'h10, 32'h0, WLEN_RD32, 1'b1, lat, enlow);
        chk("t4_latency", lat, 5);
        chk("t4_bus_addr_final", bus_addr, 32'h10);
        tick(); tick();

        // Reset during WAIT_HIGH
        m1_addr = 32'h44; m1_wlen = WLEN_RD32; m1_req = 1'b1;
        ng = 0;
        for (int i = 0; i < 10 && ng == 0; i++) begin
            tick();
            if (!bus_en_n) ng = 1;
        end
        chk("t5_granted", ng, 1);
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_en_n", bus_en_n, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_addr", bus_addr, 0);
        chk("t5_rst_gid", grant_id, 0);
        chk("t5_rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
        chk("t5_rst_acks", {m0_ack, m1_ack}, 0);
        m1_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        ng = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m1_ack || m0_ack) ng = 1;
        end
        chk("t5_no_ack", ng, 0);
        bus_rdata = 32'hCAFEF00D;
        run_txn(0, 32'h30, 32'h0, WLEN_RD32, 1'b0, lat, enlow);
        chk("t5_after_latency", lat, 5);
        chk("t5_after_rdata", m0_rdata, 32'hCAFEF00D);
        tick(); tick();

        // READY stuck high: watchdog or unbounded wait
        model_en = 1'b0;
        stub_en  = 1'b0;
        bus_rdata = 32'h0BADF00D;
        m0_addr = 32'h50; m0_wlen = WLEN_RD32; m0_req = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (m0_ack) begin
                lat = i - 1;
                chk("t6_err_with_ack", m0_err, 1);
                break;
            end
        end
        m0_req = 1'b0;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
        chk("t6_timeout_window", (lat >= 16 && lat <= 18), 1);
        chk("t6_rdata_kept", m0_rdata, 32'hCAFEF00D);
        chk("t6_idle_after", busy, 0);
`else
        chk("t6_no_ack", lat, -1);
        chk("t6_still_busy", busy, 1);
        chk("t6_no_err", m0_err, 0);
`endif
        reset = 1'b1;
        tick();
        stub_en = 1'b1;
        tick();
        reset = 1'b0;
        model_en = 1'b1;
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
